down_count_timer: RTL and testbench
===================================

DOWN_COUNT_TIMER -- requirements
Module: down_count_timer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the counter width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port load, input, 1 bit: captures load_val into the reload register and into Q.
REQ-005 The block SHALL have port load_val, input, WIDTH bits: the preset value.
REQ-006 The block SHALL have port start, input, 1 bit: begins or restarts a countdown.
REQ-007 The block SHALL have port en, input, 1 bit: count enable while running.
REQ-008 The block SHALL have port auto_reload, input, 1 bit: periodic mode select.
REQ-009 The block SHALL have port Q, output, WIDTH bits: the current count, registered.
REQ-010 The block SHALL have port tc, output, 1 bit: one-cycle terminal-count pulse, registered.
REQ-011 The block SHALL have port busy, output, 1 bit: high while in state RUN.
REQ-012 The block SHALL have port done, output, 1 bit: high while in state DONE.

Function
REQ-013 The block SHALL be a synchronous down counter with a 3-state FSM: IDLE, RUN, DONE; busy = (state==RUN), done = (state==DONE).
REQ-014 load SHALL have top priority below rst in every state: reload_reg<=load_val, Q<=load_val, state<=IDLE, tc<=0.
REQ-015 In IDLE, start=1 (load=0) SHALL go to RUN if Q!=0; if Q==0, the block SHALL go to DONE and pulse tc on the next cycle.
REQ-016 In RUN with en=1, Q SHALL decrement by exactly 1 per clock; with en=0, Q and state SHALL hold.
REQ-017 Q SHALL never underflow: there is no wrap from 0 to 2^WIDTH-1 under any input combination.
REQ-018 tc SHALL be 1 for exactly one cycle following every RUN-state edge with en=1 at which Q is written to 0; otherwise tc=0.
REQ-019 In RUN with en=1, if Q==1 and auto_reload=0, then Q<=0, tc pulses, and state<=DONE on the same edge.
REQ-020 In RUN with en=1, if Q==1 and auto_reload=1, then Q<=0 and tc pulses while the state stays in RUN.
REQ-021 In RUN with en=1 and Q==0: if auto_reload=1, Q<=reload_reg (period = reload_reg+1 enabled cycles); if auto_reload=0, the state SHALL go to DONE with Q held at 0.
REQ-022 With auto_reload=1 and reload_reg==0, the block SHALL remain in RUN with Q=0 and pulse tc on every enabled cycle.
REQ-023 In DONE, Q SHALL hold at 0.
REQ-024 In DONE, start=1 SHALL set Q<=reload_reg and state<=RUN if reload_reg!=0; otherwise the block SHALL stay in DONE and re-pulse tc.
REQ-025 start in RUN SHALL be ignored.
REQ-026 auto_reload SHALL be sampled only at the edges named in REQ-019 to REQ-021.
REQ-027 When load and start are asserted together, load SHALL win and start SHALL be ignored that cycle.
REQ-028 Simultaneous load and terminal count in RUN SHALL follow REQ-014 with tc=0.

Reset
REQ-029 rst=1 at a rising edge SHALL force Q=0, reload_reg=0, state=IDLE, tc=0, busy=0, done=0, overriding all other inputs.
REQ-030 Reset asserted mid-count SHALL abort the count with no tc pulse.
REQ-031 After rst deasserts, the block SHALL stay in IDLE until load or start.

Verification
REQ-032 One-shot: rst 1 cycle; load_val=5 with load; start; en=1 held -> Q=5,4,3,2,1,0 on successive edges, tc high one cycle after Q=0, done=1, busy=0, Q holds 0.
REQ-033 Enable gating: load 3, start, en toggled 1,0,1,0,1 -> Q=2,2,1,1,0, tc one cycle only, total 5 cycles.
REQ-034 Auto-reload: load 2, auto_reload=1, start, en=1 for 9 cycles -> Q=1,0,2,1,0,2,1,0,2; tc pulses every 3 cycles; busy stays 1; then auto_reload=0 at Q=0 -> DONE on next enabled edge.
REQ-035 Zero/restart: after rst, start -> DONE with tc pulse; load 4, start, count to DONE, start again -> Q=4, RUN.
REQ-036 Priority: load=1 and start=1 together with load_val=7 -> Q=7, IDLE; later in RUN at Q=1, load 9 with en=1 -> Q=9, IDLE, tc=0.
REQ-037 Reset mid-operation: rst at Q=3 in RUN -> next edge Q=0, IDLE, tc=0, done=0; the scoreboard checks no underflow value (2^WIDTH-1) ever appears on Q.

Source files
------------

// File: rtl/down_count_timer.sv
// Down-counting timer with preset load, enable gating, one-shot or periodic reload.
// Q, tc, busy and done are all registered; tc pulses one cycle after Q is written to 0.
module down_count_timer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             start,
   input  logic             en,
   input  logic             auto_reload,
   output logic [WIDTH-1:0] Q,
   output logic             tc,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] ZERO = '0;
   localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

   state_t           state, state_nxt;
   logic [WIDTH-1:0] q_nxt;
   logic [WIDTH-1:0] reload_reg, reload_nxt;
   logic             tc_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         Q          <= ZERO;
         reload_reg <= ZERO;
         tc         <= 1'b0;
      end else begin
         state      <= state_nxt;
         Q          <= q_nxt;
         reload_reg <= reload_nxt;
         tc         <= tc_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      q_nxt      = Q;
      reload_nxt = reload_reg;
      tc_nxt     = 1'b0;

      if (load) begin
         reload_nxt = load_val;
         q_nxt      = load_val;
         state_nxt  = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  if (Q == ZERO) begin
                     state_nxt = DONE;
                     tc_nxt    = 1'b1;
                  end else begin
                     state_nxt = RUN;
                  end
               end
            end
            RUN: begin
               if (en) begin
                  if (Q == ZERO) begin
                     // Only reachable in periodic mode after the 1->0 step
                     if (auto_reload) begin
                        q_nxt  = reload_reg;
                        tc_nxt = (reload_reg == ZERO);
                     end else begin
                        state_nxt = DONE;
                     end
                  end else if (Q == ONE) begin
                     q_nxt  = ZERO;
                     tc_nxt = 1'b1;
                     if (!auto_reload) state_nxt = DONE;
                  end else begin
                     q_nxt = Q - ONE;
                  end
               end
            end
            DONE: begin
               q_nxt = ZERO;
               if (start) begin
                  if (reload_reg != ZERO) begin
                     q_nxt     = reload_reg;
                     state_nxt = RUN;
                  end else begin
                     tc_nxt = 1'b1;
                  end
               end
            end
            default: begin
               state_nxt = IDLE;
               q_nxt     = ZERO;
            end
         endcase
      end
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);

endmodule

// File: tb/tb_down_count_timer.sv
// Bench for down_count_timer: directed vector table, then random stimulus vs a reference model.
module tb_down_count_timer;

   logic       clk = 1'b0;
   logic       rst, load, start, en, auto_reload;
   logic [3:0] load_val;
   logic [3:0] Q;
   logic       tc, busy, done;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   down_count_timer #(.WIDTH(4)) dut (
      .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start),
      .en(en), .auto_reload(auto_reload), .Q(Q), .tc(tc), .busy(busy), .done(done)
   );

   typedef struct {
      logic       r, l;
      logic [3:0] lv;
      logic       s, e, a;
      logic [3:0] eq;
      logic       etc, ebusy, edone;
   } vec_t;

   vec_t vecs[$];

   // Reference model: phase 0 idle, 1 counting, 2 expired
   int m_q, m_rel, m_phase;
   bit m_tc;

   task automatic add(input logic r, l, input logic [3:0] lv, input logic s, e, a,
                      input logic [3:0] eq, input logic etc, eb, ed);
      vec_t v;
      v.r = r; v.l = l; v.lv = lv; v.s = s; v.e = e; v.a = a;
      v.eq = eq; v.etc = etc; v.ebusy = eb; v.edone = ed;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic r, l, input logic [3:0] lv, input logic s, e, a);
      @(negedge clk);
      rst = r; load = l; load_val = lv; start = s; en = e; auto_reload = a;
      @(posedge clk);
      #1;
   endtask

   task automatic model_step(input logic r, l, input logic [3:0] lv, input logic s, e, a);
      m_tc = 1'b0;
      if (r) begin
         m_q = 0; m_rel = 0; m_phase = 0;
      end else if (l) begin
         m_q = lv; m_rel = lv; m_phase = 0;
      end else if (m_phase == 0) begin
         if (s) begin
            if (m_q == 0) begin m_phase = 2; m_tc = 1'b1; end
            else m_phase = 1;
         end
      end else if (m_phase == 1) begin
         if (e) begin
            if (m_q > 0) begin
               m_q = m_q - 1;
               if (m_q == 0) begin
                  m_tc = 1'b1;
                  if (!a) m_phase = 2;
               end
            end else if (a) begin
               m_q = m_rel;
               m_tc = (m_rel == 0);
            end else begin
               m_phase = 2;
            end
         end
      end else begin
         if (s) begin
            if (m_rel != 0) begin m_q = m_rel; m_phase = 1; end
            else m_tc = 1'b1;
         end
      end
   endtask

   initial begin
      rst = 1'b1; load = 1'b0; load_val = 4'd0; start = 1'b0; en = 1'b0; auto_reload = 1'b0;

      //   r  l  lv  s  e  a    Q  tc b  d
      add(1, 0, 0,  0, 0, 0,   0, 0, 0, 0);   // reset
      add(0, 0, 0,  0, 1, 0,   0, 0, 0, 0);   // stays idle
      add(0, 0, 0,  1, 0, 0,   0, 1, 0, 1);   // start with Q=0 -> done + tc
      add(0, 0, 0,  0, 0, 0,   0, 0, 0, 1);
      add(0, 0, 0,  1, 0, 0,   0, 1, 0, 1);   // done, reload 0: re-pulse
      // one-shot from 5
      add(0, 1, 5,  0, 0, 0,   5, 0, 0, 0);
      add(0, 0, 0,  1, 1, 0,   5, 0, 1, 0);
      add(0, 0, 0,  0, 1, 0,   4, 0, 1, 0);
      add(0, 0, 0,  0, 1, 0,   3, 0, 1, 0);
      add(0, 0, 0,  0, 1, 0,   2, 0, 1, 0);
      add(0, 0, 0,  0, 1, 0,   1, 0, 1, 0);
      add(0, 0, 0,  0, 1, 0,   0, 1, 0, 1);
      add(0, 0, 0,  0, 1, 0,   0, 0, 0, 1);
      add(0, 0, 0,  0, 1, 0,   0, 0, 0, 1);
      // enable gating from 3
      add(0, 1, 3,  0, 0, 0,   3, 0, 0, 0);
      add(0, 0, 0,  1, 0, 0,   3, 0, 1, 0);
      add(0, 0, 0,  0, 1, 0,   2, 0, 1, 0);
      add(0, 0, 0,  0, 0, 0,   2, 0, 1, 0);
      add(0, 0, 0,  0, 1, 0,   1, 0, 1, 0);
      add(0, 0, 0,  0, 0, 0,   1, 0, 1, 0);
      add(0, 0, 0,  0, 1, 0,   0, 1, 0, 1);
      add(0, 0, 0,  0, 0, 0,   0, 0, 0, 1);
      // restart from done
      add(0, 1, 4,  0, 0, 0,   4, 0, 0, 0);
      add(0, 0, 0,  1, 0, 0,   4, 0, 1, 0);
      add(0, 0, 0,  0, 1, 0,   3, 0, 1, 0);
      add(0, 0, 0,  0, 1, 0,   2, 0, 1, 0);
      add(0, 0, 0,  0, 1, 0,   1, 0, 1, 0);
      add(0, 0, 0,  0, 1, 0,   0, 1, 0, 1);
      add(0, 0, 0,  1, 0, 0,   4, 0, 1, 0);
      add(0, 0, 0,  1, 0, 0,   4, 0, 1, 0);   // start ignored in RUN
      // periodic from 2
      add(0, 1, 2,  0, 0, 1,   2, 0, 0, 0);
      add(0, 0, 0,  1, 0, 1,   2, 0, 1, 0);
      add(0, 0, 0,  0, 1, 1,   1, 0, 1, 0);
      add(0, 0, 0,  0, 1, 1,   0, 1, 1, 0);
      add(0, 0, 0,  0, 1, 1,   2, 0, 1, 0);
      add(0, 0, 0,  0, 1, 1,   1, 0, 1, 0);
      add(0, 0, 0,  0, 1, 1,   0, 1, 1, 0);
      add(0, 0, 0,  0, 1, 1,   2, 0, 1, 0);
      add(0, 0, 0,  0, 1, 1,   1, 0, 1, 0);
      add(0, 0, 0,  0, 1, 1,   0, 1, 1, 0);
      add(0, 0, 0,  0, 1, 1,   2, 0, 1, 0);
      add(0, 0, 0,  0, 1, 1,   1, 0, 1, 0);
      add(0, 0, 0,  0, 1, 1,   0, 1, 1, 0);
      add(0, 0, 0,  0, 1, 0,   0, 0, 0, 1);   // periodic off at Q=0
      // load beats start; load beats terminal count
      add(0, 1, 7,  1, 0, 0,   7, 0, 0, 0);
      add(0, 0, 0,  1, 0, 0,   7, 0, 1, 0);
      add(0, 0, 0,  0, 1, 0,   6, 0, 1, 0);
      add(0, 0, 0,  0, 1, 0,   5, 0, 1, 0);
      add(0, 0, 0,  0, 1, 0,   4, 0, 1, 0);
      add(0, 0, 0,  0, 1, 0,   3, 0, 1, 0);
      add(0, 0, 0,  0, 1, 0,   2, 0, 1, 0);
      add(0, 0, 0,  0, 1, 0,   1, 0, 1, 0);
      add(0, 1, 9,  0, 1, 0,   9, 0, 0, 0);
      // reset mid-count
      add(0, 0, 0,  1, 0, 0,   9, 0, 1, 0);
      add(0, 0, 0,  0, 1, 0,   8, 0, 1, 0);
      add(0, 0, 0,  0, 1, 0,   7, 0, 1, 0);
      add(0, 0, 0,  0, 1, 0,   6, 0, 1, 0);
      add(0, 0, 0,  0, 1, 0,   5, 0, 1, 0);
      add(0, 0, 0,  0, 1, 0,   4, 0, 1, 0);
      add(0, 0, 0,  0, 1, 0,   3, 0, 1, 0);
      add(1, 0, 0,  1, 1, 1,   0, 0, 0, 0);
      add(0, 0, 0,  0, 1, 0,   0, 0, 0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].r, vecs[i].l, vecs[i].lv, vecs[i].s, vecs[i].e, vecs[i].a);
         check($sformatf("vec%0d_q", i),    Q,    vecs[i].eq);
         check($sformatf("vec%0d_tc", i),   tc,   vecs[i].etc);
         check($sformatf("vec%0d_busy", i), busy, vecs[i].ebusy);
         check($sformatf("vec%0d_done", i), done, vecs[i].edone);
         if (Q == 4'hF) begin
            n_tests++;
            n_fail++;
            $display("FAIL vec%0d_underflow: got Q=%0d, all-ones never loaded here", i, Q);
         end
      end

      // Random phase against the reference model
      m_q = 0; m_rel = 0; m_phase = 0; m_tc = 1'b0;
      drive(1, 0, 0, 0, 0, 0);
      model_step(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3000; i++) begin
         logic       r, l, s, e, a;
         logic [3:0] lv;
         r  = ($urandom_range(0, 99) < 2);
         l  = ($urandom_range(0, 99) < 6);
         lv = 4'($urandom_range(0, 15));
         s  = ($urandom_range(0, 99) < 15);
         e  = ($urandom_range(0, 99) < 75);
         a  = ($urandom_range(0, 99) < 40);
         drive(r, l, lv, s, e, a);
         model_step(r, l, lv, s, e, a);
         check("rnd_q",    Q,    m_q);
         check("rnd_tc",   tc,   m_tc);
         check("rnd_busy", busy, m_phase == 1);
         check("rnd_done", done, m_phase == 2);
         if (n_fail > 20) break;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
